fan_tach_meter: RTL
===================

Name: fan_tach_meter

Overview:
- Upstream measurement stage for the fan controller: converts the fan's open-drain tachometer signal into an 8-bit speed value plus a one-cycle valid strobe.
- Output pair (speed_o, speed_valid_o) maps directly onto the controller's measured-value load path, so a real tach feedback replaces the manually strobed ADC value.
- Internals: input synchronisation, debounce, edge counting over a fixed gate window, saturation/scaling, warm-up discard and stall detection.

Parameters:
- ADC_BITWIDTH, 8, width of speed_o; matches the controller's measured-value width.
- CNT_W, 12, width of the internal pulse counter.
- GATE_TICKS, 100, clk_en_i ticks per measurement window (≥2).
- DEBOUNCE_LEN, 3, consecutive enabled samples needed to accept a level change (≥1).
- SCALE_SHIFT, 0, left shift applied to the pulse count before saturation.
- STALL_WINDOWS, 2, consecutive zero-pulse windows that assert stall_o (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- clk_en_i  in  1  sample/gate tick, one clk wide, from the existing clock-enable divider.
- tach_i  in  1  asynchronous tach input, idle-high (pulled up).
- speed_o  out  ADC_BITWIDTH  last completed window's scaled, saturated pulse count.
- speed_valid_o  out  1  one-cycle strobe when speed_o updates.
- stall_o  out  1  fan-stalled flag (level).

Behaviour:
- Reset values (synchronous, rst_n low at posedge clk): sync FFs = 1, filtered level = 1, debounce count = 0, window count = 0, pulse count = 0, stall count = 0, state = WARMUP, speed_o = 0, speed_valid_o = 0, stall_o = 0.
- Reset mid-window discards all partial counts. No output glitches beyond the reset values above.
- Synchroniser: 2-FF chain clocked every clk, not gated by clk_en_i.
- Debounce: updates only on clk_en_i.
  - If synced ≠ filtered, increment the debounce count.
  - When the count reaches DEBOUNCE_LEN-1 on a tick where synced still ≠ filtered, toggle filtered and clear the count.
  - If synced == filtered, clear the count.
- Pulse: a rising edge of the filtered level (0→1), detected on the clk_en_i tick where the toggle happens.
- Pulse counter: increments per pulse and saturates at 2^CNT_W-1.
- Window counter: increments on clk_en_i, range 0..GATE_TICKS-1. The tick at GATE_TICKS-1 is the window end; the counter wraps to 0.
- Window end:
  - total = pulse count plus the pulse on this tick, if any.
  - The next window's pulse count restarts at 0. A pulse on the end tick belongs to the ending window.
- FSM states:
  - WARMUP: first window after reset. At window end, outputs are not updated, no strobe, stall logic untouched; go to MEASURE.
  - MEASURE: at every window end, update outputs as below. Stays in MEASURE until reset.
- Output update (MEASURE, window end):
  - scaled = total << SCALE_SHIFT, computed wide enough to avoid overflow.
  - speed_o = min(scaled, 2^ADC_BITWIDTH-1).
  - speed_o and speed_valid_o are registered: valid is high for exactly the one clk after the window-end tick edge; speed_o is stable from that cycle until the next update.
- Stall:
  - total == 0: stall count increments, saturating at STALL_WINDOWS.
  - total > 0: stall count clears.
  - stall_o = (stall count == STALL_WINDOWS), registered and updated in the same cycle as speed_valid_o.
- clk_en_i low: nothing advances except the synchroniser. speed_valid_o still self-clears after one cycle.

Decomposition:
- Shared package (the fan-control constants package):
  - ADC_BITWIDTH default.
  - tach FSM state encoding (WARMUP, MEASURE).
  - saturate-to-width helper function, shared with the PWM/PID path.
- Sub-module: tach_debounce (synchroniser + debounce + rising-edge pulse output). It is reusable for the config/strobe pins.

Test Plan:
- Reset/warm-up: clk_en_i tied 1; 10 clean tach pulses (high 5 / low 5 clk) in the first window → no speed_valid_o in window 1. Window 2 with the same stimulus → speed_valid_o one cycle after tick 99, speed_o = 10, stall_o = 0.
- Debounce: 1–2 clk low glitches on idle-high tach_i for 3 windows → speed_o = 0 each window. stall_o rises at the 2nd MEASURE window end and stays 1.
- Stall recovery: after the stall, 4 clean pulses in one window → speed_o = 4, stall_o = 0 in the same valid cycle.
- Saturation: SCALE_SHIFT = 2, 70 pulses per window → speed_o = 255 (280 clipped). 63 pulses → speed_o = 252.
- Boundary edge: filtered rising edge lands exactly on tick 99 → counted in the ending window (speed_o = N+1), next window starts at 0.
- Mid-window reset: assert rst_n low at tick 50 of a MEASURE window → all outputs 0, state WARMUP, first strobe only after two full windows post-reset.

Source files
------------

// File: rtl/fan_tach_meter_pkg.sv
// Shared fan-control constants: default measured-value width, tach FSM encoding
// and the saturate-to-width helper also used by the PWM/PID path.
package fan_tach_meter_pkg;

    localparam int unsigned DEF_ADC_BITWIDTH = 8;

    typedef enum logic {
        StWarmup  = 1'b0,
        StMeasure = 1'b1
    } tach_state_e;

    function automatic logic [31:0] sat_to_width(input logic [31:0] i_val,
                                                 input int unsigned i_width);
        logic [31:0] w_max;
        w_max = (i_width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << i_width) - 32'd1);
        return (i_val > w_max) ? w_max : i_val;
    endfunction

endpackage

// File: rtl/fan_tach_meter_debounce.sv
// Two-FF synchroniser plus enable-gated debounce; emits a one-tick pulse on each
// accepted rising edge of the filtered level. Reusable for slow config/strobe pins.
module tach_debounce #(
    parameter int unsigned DEBOUNCE_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_en_i,
    input  logic async_i,
    output logic rise_o
);

    localparam int unsigned CW = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LEN - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_toggle;

    assign w_diff   = (r_sync2 != r_filt);
    assign w_toggle = clk_en_i && w_diff && (r_cnt == LAST);
    assign rise_o   = w_toggle && !r_filt;

    // Synchroniser runs every clk so metastability settles regardless of the enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= async_i;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_filt <= 1'b1;
            r_cnt  <= '0;
        end else if (clk_en_i) begin
            if (w_toggle) begin
                r_filt <= ~r_filt;
                r_cnt  <= '0;
            end else if (w_diff) begin
                r_cnt  <= r_cnt + 1'b1;
            end else begin
                r_cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/fan_tach_meter.sv
// Tachometer front end: counts debounced rising edges over a gate window and
// publishes a scaled, saturated speed with a valid strobe and a stall flag.
module fan_tach_meter
    import fan_tach_meter_pkg::*;
#(
    parameter int unsigned ADC_BITWIDTH  = DEF_ADC_BITWIDTH,
    parameter int unsigned CNT_W         = 12,
    parameter int unsigned GATE_TICKS    = 100,
    parameter int unsigned DEBOUNCE_LEN  = 3,
    parameter int unsigned SCALE_SHIFT   = 0,
    parameter int unsigned STALL_WINDOWS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en_i,
    input  logic                    tach_i,
    output logic [ADC_BITWIDTH-1:0] speed_o,
    output logic                    speed_valid_o,
    output logic                    stall_o
);

    localparam int unsigned WIN_W   = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;
    localparam int unsigned STALL_W = $clog2(STALL_WINDOWS + 1);
    localparam int unsigned TOT_W   = CNT_W + 1;
    localparam int unsigned SCL_W   = TOT_W + SCALE_SHIFT;

    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(GATE_TICKS - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_WINDOWS);

    logic                    w_rise;
    logic                    w_end;
    logic                    w_update;
    logic [TOT_W-1:0]        w_total;
    logic [SCL_W-1:0]        w_scaled;
    logic [ADC_BITWIDTH-1:0] w_speed;
    logic [STALL_W-1:0]      w_stall_cnt_d;
    tach_state_e             w_state_d;

    tach_state_e             r_state;
    logic [WIN_W-1:0]        r_win;
    logic [CNT_W-1:0]        r_pulse;
    logic [STALL_W-1:0]      r_stall_cnt;
    logic [ADC_BITWIDTH-1:0] r_speed;
    logic                    r_valid;
    logic                    r_stall;

    tach_debounce #(
        .DEBOUNCE_LEN (DEBOUNCE_LEN)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en_i (clk_en_i),
        .async_i  (tach_i),
        .rise_o   (w_rise)
    );

    assign w_end = clk_en_i && (r_win == WIN_LAST);

    // A pulse landing on the end tick still belongs to the window that is closing.
    assign w_total  = {1'b0, r_pulse} + TOT_W'(w_rise);
    assign w_scaled = SCL_W'(w_total) << SCALE_SHIFT;
    assign w_speed  = ADC_BITWIDTH'(sat_to_width(32'(w_scaled), ADC_BITWIDTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_win   <= '0;
            r_pulse <= '0;
        end else if (clk_en_i) begin
            r_win <= w_end ? '0 : r_win + 1'b1;
            if (w_end) begin
                r_pulse <= '0;
            end else if (w_rise && (r_pulse != CNT_MAX)) begin
                r_pulse <= r_pulse + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StWarmup;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StWarmup:  if (w_end) w_state_d = StMeasure;
            StMeasure: w_state_d = StMeasure;
            default:   w_state_d = StWarmup;
        endcase
    end

    always_comb begin
        w_update = 1'b0;
        unique case (r_state)
            StWarmup:  w_update = 1'b0;
            StMeasure: w_update = w_end;
            default:   w_update = 1'b0;
        endcase
    end

    always_comb begin
        w_stall_cnt_d = '0;
        if (w_total == '0) begin
            w_stall_cnt_d = (r_stall_cnt == STALL_MAX) ? STALL_MAX : r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_speed     <= '0;
            r_valid     <= 1'b0;
            r_stall     <= 1'b0;
        end else begin
            r_valid <= w_update;
            if (w_update) begin
                r_stall_cnt <= w_stall_cnt_d;
                r_speed     <= w_speed;
                r_stall     <= (w_stall_cnt_d == STALL_MAX);
            end
        end
    end

    assign speed_o       = r_speed;
    assign speed_valid_o = r_valid;
    assign stall_o       = r_stall;

endmodule
